// File: rtl/mac_div.sv
// Sequential signed divider for MAC results: 2*LEN-bit dividend by LEN-bit divisor,
// restoring shift-subtract on magnitudes, then sign fix-up with saturation.
module mac_div #(
  parameter int unsigned LEN = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*LEN-1:0]    dividend,
  input  logic [LEN-1:0]      divisor,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LEN-1:0]      quot,
  output logic [LEN-1:0]      rem,
  output logic                overflow,
  output logic                div_by_zero
);

  localparam int unsigned DW = 2 * LEN;
  localparam int unsigned MW = DW + 1;
  localparam int unsigned CW = $clog2(DW + 1);

  localparam logic [LEN-1:0] QMAX    = {1'b0, {(LEN-1){1'b1}}};
  localparam logic [LEN-1:0] QMIN    = {1'b1, {(LEN-1){1'b0}}};
  localparam logic [MW-1:0]  POS_LIM = MW'(QMAX);
  localparam logic [MW-1:0]  NEG_LIM = MW'(QMIN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          r_state;
  state_t          w_next;

  logic [MW-1:0]   r_dvd;
  logic [LEN:0]    r_dsr;
  logic [LEN-1:0]  r_prem;
  logic [CW-1:0]   r_cnt;
  logic            r_dvd_neg;
  logic            r_q_neg;
  logic            r_dbz;

  logic            r_in_ready;
  logic            r_out_valid;
  logic [LEN-1:0]  r_quot;
  logic [LEN-1:0]  r_rem;
  logic            r_ovf;
  logic            r_dbz_o;

  logic [MW-1:0]   w_dvd_ext;
  logic [MW-1:0]   w_dvd_mag;
  logic [LEN:0]    w_dsr_ext;
  logic [LEN:0]    w_dsr_mag;
  logic [LEN:0]    w_shift;
  logic            w_ge;
  logic [LEN-1:0]  w_diff;
  logic [LEN-1:0]  w_q_negv;
  logic [LEN-1:0]  w_rem_negv;
  logic [LEN-1:0]  w_quot_fix;
  logic [LEN-1:0]  w_rem_fix;
  logic            w_ovf_fix;

  // Magnitudes are one bit wider than the operands so the most negative value does not wrap
  assign w_dvd_ext = {dividend[DW-1], dividend};
  assign w_dvd_mag = dividend[DW-1] ? (~w_dvd_ext + MW'(1)) : w_dvd_ext;
  assign w_dsr_ext = {divisor[LEN-1], divisor};
  assign w_dsr_mag = divisor[LEN-1] ? (~w_dsr_ext + (LEN+1)'(1)) : w_dsr_ext;

  // One restoring step: shift next dividend bit into partial remainder, trial subtract
  assign w_shift = {r_prem, r_dvd[DW-1]};
  assign w_ge    = (w_shift >= r_dsr);
  assign w_diff  = LEN'(w_shift - r_dsr);

  assign w_q_negv   = ~r_dvd[LEN-1:0] + LEN'(1);
  assign w_rem_negv = ~r_prem + LEN'(1);

  // Sign correction and saturation of the finished magnitudes
  always_comb begin
    w_quot_fix = r_dvd[LEN-1:0];
    w_rem_fix  = r_dvd_neg ? w_rem_negv : r_prem;
    w_ovf_fix  = 1'b0;
    if (r_dbz) begin
      w_quot_fix = r_dvd_neg ? QMIN : QMAX;
      w_rem_fix  = '0;
      w_ovf_fix  = 1'b1;
    end else if (!r_q_neg) begin
      if (r_dvd > POS_LIM) begin
        w_quot_fix = QMAX;
        w_rem_fix  = '0;
        w_ovf_fix  = 1'b1;
      end
    end else begin
      if (r_dvd > NEG_LIM) begin
        w_quot_fix = QMIN;
        w_rem_fix  = '0;
        w_ovf_fix  = 1'b1;
      end else begin
        w_quot_fix = w_q_negv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (in_valid && r_in_ready) w_next = (divisor == '0) ? FIX : CALC;
      CALC: if (r_cnt == CW'(DW - 1)) w_next = FIX;
      FIX:  w_next = DONE;
      DONE: if (r_out_valid && out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Datapath and registered outputs; out_valid rises one cycle after entering DONE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_dvd_neg   <= 1'b0;
      r_q_neg     <= 1'b0;
      r_dbz       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_quot      <= '0;
      r_rem       <= '0;
      r_ovf       <= 1'b0;
      r_dbz_o     <= 1'b0;
    end else begin
      r_in_ready  <= (w_next == IDLE);
      r_out_valid <= (r_state == DONE) && (w_next == DONE);
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_dvd     <= w_dvd_mag;
            r_dsr     <= w_dsr_mag;
            r_prem    <= '0;
            r_cnt     <= '0;
            r_dvd_neg <= dividend[DW-1];
            r_q_neg   <= dividend[DW-1] ^ divisor[LEN-1];
            r_dbz     <= (divisor == '0);
          end
        end
        CALC: begin
          r_dvd  <= {1'b0, r_dvd[DW-2:0], w_ge};
          r_prem <= w_ge ? w_diff : w_shift[LEN-1:0];
          r_cnt  <= r_cnt + CW'(1);
        end
        FIX: begin
          r_quot  <= w_quot_fix;
          r_rem   <= w_rem_fix;
          r_ovf   <= w_ovf_fix;
          r_dbz_o <= r_dbz;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quot        = r_quot;
  assign rem         = r_rem;
  assign overflow    = r_ovf;
  assign div_by_zero = r_dbz_o;

endmodule

// File: tb/tb_mac_div.sv
// Directed bench for mac_div (LEN=9): vector table with hand-computed results,
// plus back-pressure and mid-operation reset sequences.
module tb_mac_div;

  localparam int unsigned L = 9;

  typedef struct {
    logic [2*L-1:0] dvd;
    logic [L-1:0]   dsr;
    logic [L-1:0]   q;
    logic [L-1:0]   r;
    logic           ovf;
    logic           dbz;
    int             lat;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [2*L-1:0] dividend;
  logic [L-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [L-1:0]   quot;
  logic [L-1:0]   rem;
  logic           overflow;
  logic           div_by_zero;

  int n_vec  = 0;
  int n_fail = 0;

  vec_t tbl[$];

  mac_div #(.LEN(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quot(quot), .rem(rem), .overflow(overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(int dvd, int dsr, int q, int r, bit ovf, bit dbz);
    vec_t v;
    v.dvd = 18'(dvd);
    v.dsr = 9'(dsr);
    v.q   = 9'(q);
    v.r   = 9'(r);
    v.ovf = ovf;
    v.dbz = dbz;
    v.lat = dbz ? 2 : 20;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (!in_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'(1));
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run_op(input vec_t v, input string tag);
    int lat;
    out_ready = 1'b1;
    wait_ready(tag);
    in_valid = 1'b1;
    dividend = v.dvd;
    divisor  = v.dsr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = 18'($urandom);
    divisor  = 9'($urandom);
    wait_valid(lat);
    check({tag, " latency"}, 32'(lat), 32'(v.lat));
    check({tag, " quot"},    32'(quot), 32'(v.q));
    check({tag, " rem"},     32'(rem), 32'(v.r));
    check({tag, " overflow"}, 32'(overflow), 32'(v.ovf));
    check({tag, " div_by_zero"}, 32'(div_by_zero), 32'(v.dbz));
    check({tag, " in_ready in DONE"}, 32'(in_ready), 32'(0));
    @(posedge clk); #1;
    check({tag, " out_valid after accept"}, 32'(out_valid), 32'(0));
    check({tag, " in_ready after accept"}, 32'(in_ready), 32'(1));
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    bit seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check({tag, " no spurious out_valid"}, 32'(seen), 32'(0));
  endtask

  initial begin
    int   lat;
    vec_t v;

    tbl.push_back(mk(8800,    88,   100,    0, 1'b0, 1'b0));
    tbl.push_back(mk(-1000,   7,    -142,  -6, 1'b0, 1'b0));
    tbl.push_back(mk(-1024,   -32,  32,     0, 1'b0, 1'b0));
    tbl.push_back(mk(65535,   1,    255,    0, 1'b1, 1'b0));
    tbl.push_back(mk(-256,    1,    -256,   0, 1'b0, 1'b0));
    tbl.push_back(mk(100,     0,    255,    0, 1'b1, 1'b1));
    tbl.push_back(mk(-5,      0,    -256,   0, 1'b1, 1'b1));
    tbl.push_back(mk(0,       0,    255,    0, 1'b1, 1'b1));
    tbl.push_back(mk(-131072, -1,   255,    0, 1'b1, 1'b0));
    tbl.push_back(mk(1000,    -7,   -142,   6, 1'b0, 1'b0));
    tbl.push_back(mk(32767,   128,  255,  127, 1'b0, 1'b0));
    tbl.push_back(mk(32768,   128,  255,    0, 1'b1, 1'b0));
    tbl.push_back(mk(65536,   -256, -256,   0, 1'b0, 1'b0));
    tbl.push_back(mk(-7,      100,  0,     -7, 1'b0, 1'b0));
    tbl.push_back(mk(-32769,  128,  -256,  -1, 1'b0, 1'b0));
    tbl.push_back(mk(-32896,  128,  -256,   0, 1'b1, 1'b0));

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready",    32'(in_ready), 32'(1));
    check("reset out_valid",   32'(out_valid), 32'(0));
    check("reset quot",        32'(quot), 32'(0));
    check("reset rem",         32'(rem), 32'(0));
    check("reset overflow",    32'(overflow), 32'(0));
    check("reset div_by_zero", 32'(div_by_zero), 32'(0));
    reset = 1'b0;

    foreach (tbl[i]) run_op(tbl[i], $sformatf("v%0d", i));

    // Back-pressure: result held 5 cycles, and a pending request is not taken in DONE
    out_ready = 1'b0;
    wait_ready("bp");
    in_valid = 1'b1;
    dividend = 18'(8800);
    divisor  = 9'(88);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_valid(lat);
    check("bp latency", 32'(lat), 32'(20));
    in_valid = 1'b1;
    dividend = 18'(50);
    divisor  = 9'(5);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("bp hold%0d out_valid", c), 32'(out_valid), 32'(1));
      check($sformatf("bp hold%0d in_ready", c), 32'(in_ready), 32'(0));
      check($sformatf("bp hold%0d quot", c), 32'(quot), 32'(100));
      check($sformatf("bp hold%0d rem", c), 32'(rem), 32'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp release in_ready",  32'(in_ready), 32'(1));
    check("bp release out_valid", 32'(out_valid), 32'(0));
    check_quiet("bp", 25);

    // Reset 7 cycles into CALC discards the operation
    wait_ready("rst");
    in_valid = 1'b1;
    dividend = 18'(-1000);
    divisor  = 9'(7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst in_ready",    32'(in_ready), 32'(1));
    check("midrst out_valid",   32'(out_valid), 32'(0));
    check("midrst quot",        32'(quot), 32'(0));
    check("midrst rem",         32'(rem), 32'(0));
    check("midrst overflow",    32'(overflow), 32'(0));
    check("midrst div_by_zero", 32'(div_by_zero), 32'(0));
    check_quiet("midrst", 30);
    v = mk(-1000, 7, -142, -6, 1'b0, 1'b0);
    run_op(v, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
